// File: rtl/l1d_wb_cache.sv
// Set-associative write-back / write-allocate L1 data cache with true-LRU replacement.
// Line fill and eviction move one 32-bit word per beat over a valid/ready memory port.
module l1d_wb_cache #(
    parameter int SETS       = 256,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_store,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    input  logic [3:0]  cpu_req_wstrb,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_store,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(SETS);
    localparam int WW   = $clog2(WAYS);
    localparam int TAGW = 32 - 2 - OFF - IDX;

    // state       | meaning
    // IDLE        | ready for a CPU request
    // LOOKUP      | tag compare, hit update or victim choice
    // WRITEBACK   | streaming dirty victim line out, one word per beat
    // REFILL_REQ  | issuing the read beat for the current refill word
    // REFILL_WAIT | waiting for that word's read data
    // RESP        | one-cycle CPU response
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_RESP, S_WRITEBACK, S_REFILL_REQ, S_REFILL_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [TAGW-1:0] req_tag_q;
    logic [IDX-1:0]  req_idx_q;
    logic [OFF-1:0]  req_off_q;
    logic            req_store_q;
    logic [31:0]     req_wdata_q;
    logic [3:0]      req_wstrb_q;
    logic [OFF-1:0]  beat_q;
    logic [WW-1:0]   victim_q;
    logic [TAGW-1:0] victim_tag_q;
    logic            first_q;
    logic [31:0]     rdata_q;

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WW-1:0]   age_q   [SETS][WAYS];
    logic [TAGW-1:0] tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][LINE_WORDS];

    logic            hit;
    logic [WW-1:0]   hit_way;
    logic            has_inv;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   lru_way;
    logic [WW-1:0]   victim;
    logic [31:0]     hit_word;
    logic [31:0]     merged_word;
    logic            beat_last;
    logic            victim_dirty;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_req_addr[1:0];

    assign beat_last = (beat_q == OFF'(LINE_WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the oldest way.
    always_comb begin
        has_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx_q][w]) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_idx_q][w] == WW'(WAYS - 1)) begin
                lru_way = WW'(w);
            end
        end
        victim       = has_inv ? inv_way : lru_way;
        victim_dirty = valid_q[req_idx_q][victim] && dirty_q[req_idx_q][victim];
    end

    always_comb begin
        hit_word    = data_q[req_idx_q][hit_way][req_off_q];
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (req_wstrb_q[b]) begin
                merged_word[8*b +: 8] = req_wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit)               state_d = S_RESP;
                else if (victim_dirty) state_d = S_WRITEBACK;
                else                   state_d = S_REFILL_REQ;
            end
            S_WRITEBACK: begin
                if (mem_req_ready && beat_last) state_d = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                if (mem_req_ready) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_rsp_valid) state_d = beat_last ? S_LOOKUP : S_REFILL_REQ;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        cpu_rsp_rdata = '0;
        mem_req_valid = 1'b0;
        mem_req_store = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state_q)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
            end
            S_RESP: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_rdata = rdata_q;
            end
            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_store = 1'b1;
                mem_req_addr  = {victim_tag_q, req_idx_q, beat_q, 2'b00};
                mem_req_wdata = data_q[req_idx_q][victim_q][beat_q];
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag_q, req_idx_q, beat_q, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_off_q    <= '0;
            req_store_q  <= 1'b0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            beat_q       <= '0;
            victim_q     <= '0;
            victim_tag_q <= '0;
            first_q      <= 1'b0;
            rdata_q      <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WW'(w);
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        req_tag_q   <= cpu_req_addr[31 -: TAGW];
                        req_idx_q   <= cpu_req_addr[2 + OFF +: IDX];
                        req_off_q   <= cpu_req_addr[2 +: OFF];
                        req_store_q <= cpu_req_store;
                        req_wdata_q <= cpu_req_wdata;
                        req_wstrb_q <= cpu_req_wstrb;
                        first_q     <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (first_q) begin
                        if (hit) hit_cnt  <= hit_cnt + 32'd1;
                        else     miss_cnt <= miss_cnt + 32'd1;
                    end
                    if (hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WW'(w) == hit_way) begin
                                age_q[req_idx_q][w] <= '0;
                            end else if (age_q[req_idx_q][w] < age_q[req_idx_q][hit_way]) begin
                                age_q[req_idx_q][w] <= age_q[req_idx_q][w] + 1'b1;
                            end
                        end
                        if (req_store_q) dirty_q[req_idx_q][hit_way] <= 1'b1;
                        rdata_q <= req_store_q ? 32'd0 : hit_word;
                    end else begin
                        victim_q     <= victim;
                        victim_tag_q <= tag_q[req_idx_q][victim];
                        beat_q       <= '0;
                    end
                end
                S_WRITEBACK: begin
                    // Beat counter wraps to 0 after the last word, ready for the refill.
                    if (mem_req_ready) beat_q <= beat_q + 1'b1;
                end
                S_REFILL_WAIT: begin
                    if (mem_rsp_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_last) begin
                            valid_q[req_idx_q][victim_q] <= 1'b1;
                            dirty_q[req_idx_q][victim_q] <= 1'b0;
                            first_q                      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && hit && req_store_q) begin
            data_q[req_idx_q][hit_way][req_off_q] <= merged_word;
        end
        if (state_q == S_REFILL_WAIT && mem_rsp_valid) begin
            data_q[req_idx_q][victim_q][beat_q] <= mem_rsp_rdata;
            if (beat_last) begin
                tag_q[req_idx_q][victim_q] <= req_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_l1d_wb_cache.sv
// Directed bench for l1d_wb_cache (4 sets, 2 ways, 4-word lines) against a behavioural memory
// that returns A^0x5A5A0000 for word address A.
module tb_l1d_wb_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_store;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic [3:0]  cpu_req_wstrb;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_req_store;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    l1d_wb_cache #(.SETS(4), .WAYS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_store(cpu_req_store), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_store(mem_req_store), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] shadow [logic [31:0]];
    int          stall_at = -1;
    int          stall_left = 0;
    bit          release_chk = 1'b0;
    logic [31:0] snap_a, snap_d;
    bit          rsp_pend = 1'b0;
    logic [31:0] pend_addr;
    int          rsp_seen = 0;

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        int          n_rd;
        int          n_wr;
        logic [31:0] rf_base;
        logic [31:0] wb_base;
        int          lat;
        int          hits;
        int          misses;
        bit          stall;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sh(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : (a ^ 32'h5A5A0000);
    endfunction

    function automatic vec_t mk(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] sb, input logic [31:0] erd, input int nrd,
                                input int nwr, input logic [31:0] rf, input logic [31:0] wb,
                                input int lat, input int h, input int m, input bit stall);
        vec_t v;
        v.st = st; v.addr = addr; v.wdata = wd; v.strb = sb; v.exp_rd = erd;
        v.n_rd = nrd; v.n_wr = nwr; v.rf_base = rf; v.wb_base = wb; v.lat = lat;
        v.hits = h; v.misses = m; v.stall = stall;
        return v;
    endfunction

    // Memory: read data one cycle after the read handshake; optional 5-cycle ready stall.
    always @(negedge clk) begin
        if (rsp_pend) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = pend_addr ^ 32'h5A5A0000;
            rsp_pend      = 1'b0;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = '0;
        end
        if (stall_left > 0) begin
            if (stall_left == 5) begin
                snap_a = mem_req_addr;
                snap_d = mem_req_wdata;
            end else begin
                check("stall_valid", {31'd0, mem_req_valid}, 32'd1);
                check("stall_addr", mem_req_addr, snap_a);
                check("stall_wdata", mem_req_wdata, snap_d);
            end
            mem_req_ready = 1'b0;
            stall_left--;
            if (stall_left == 0) release_chk = 1'b1;
        end else begin
            mem_req_ready = 1'b1;
            if (release_chk) begin
                check("release_addr", mem_req_addr, snap_a);
                check("release_wdata", mem_req_wdata, snap_d);
                release_chk = 1'b0;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_store) begin
                wr_q.push_back(mem_req_addr);
                wd_q.push_back(mem_req_wdata);
                if (stall_at >= 0 && wr_q.size() == stall_at) begin
                    stall_left = 5;
                    stall_at   = -1;
                end
            end else begin
                rd_q.push_back(mem_req_addr);
                rsp_pend  = 1'b1;
                pend_addr = mem_req_addr;
            end
        end
        if (cpu_rsp_valid) rsp_seen++;
    end

    task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] sb, output logic [31:0] rd, output int lat,
                          output bit ok);
        int n;
        @(negedge clk); #1;
        cpu_req_valid = 1'b1;
        cpu_req_store = st;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
        cpu_req_wstrb = sb;
        n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk); #1;
        cpu_req_valid = 1'b0;
        lat = 1;
        ok  = 1'b0;
        rd  = 'x;
        while (lat < 200) begin
            if (cpu_rsp_valid) begin
                ok = 1'b1;
                rd = cpu_rsp_rdata;
                break;
            end
            @(negedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[19];
    logic [31:0] rd;
    logic [31:0] w;
    int          lat;
    bit          ok;
    int          nr0, nw0, rs0, n;

    initial begin
        rst = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_store = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        cpu_req_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_ready", {31'd0, cpu_req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, cpu_rsp_valid}, 32'd0);
        check("reset_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        check("reset_hit_cnt", hit_cnt, 32'd0);
        check("reset_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;

        //             st  addr      wdata         strb     exp_rd        rd wr rf      wb      lat h   m  stall
        tbl[0]  = mk(0, 32'h040, 32'h0,        4'h0, 32'h5A5A0040, 4, 0, 32'h040, 32'h0,   0,  0, 1, 0);
        tbl[1]  = mk(0, 32'h044, 32'h0,        4'h0, 32'h5A5A0044, 0, 0, 32'h0,   32'h0,   2,  1, 1, 0);
        tbl[2]  = mk(1, 32'h048, 32'hDEADBEEF, 4'h3, 32'h0,        0, 0, 32'h0,   32'h0,   2,  2, 1, 0);
        tbl[3]  = mk(0, 32'h048, 32'h0,        4'h0, 32'h5A5ABEEF, 0, 0, 32'h0,   32'h0,   2,  3, 1, 0);
        tbl[4]  = mk(0, 32'h080, 32'h0,        4'h0, 32'h5A5A0080, 4, 0, 32'h080, 32'h0,   0,  3, 2, 0);
        tbl[5]  = mk(0, 32'h0C0, 32'h0,        4'h0, 32'h5A5A00C0, 4, 4, 32'h0C0, 32'h040, 0,  3, 3, 0);
        tbl[6]  = mk(1, 32'h0C4, 32'h11223344, 4'h8, 32'h0,        0, 0, 32'h0,   32'h0,   2,  4, 3, 0);
        tbl[7]  = mk(0, 32'h0C4, 32'h0,        4'h0, 32'h115A00C4, 0, 0, 32'h0,   32'h0,   2,  5, 3, 0);
        tbl[8]  = mk(1, 32'h0CC, 32'hAABBCCDD, 4'h6, 32'h0,        0, 0, 32'h0,   32'h0,   2,  6, 3, 0);
        tbl[9]  = mk(0, 32'h0CC, 32'h0,        4'h0, 32'h5ABBCCCC, 0, 0, 32'h0,   32'h0,   2,  7, 3, 0);
        tbl[10] = mk(0, 32'h084, 32'h0,        4'h0, 32'h5A5A0084, 0, 0, 32'h0,   32'h0,   2,  8, 3, 0);
        tbl[11] = mk(0, 32'h100, 32'h0,        4'h0, 32'h5A5A0100, 4, 4, 32'h100, 32'h0C0, 0,  8, 4, 0);
        tbl[12] = mk(0, 32'h050, 32'h0,        4'h0, 32'h5A5A0050, 4, 0, 32'h050, 32'h0,   0,  8, 5, 0);
        tbl[13] = mk(0, 32'h05C, 32'h0,        4'h0, 32'h5A5A005C, 0, 0, 32'h0,   32'h0,   2,  9, 5, 0);
        tbl[14] = mk(1, 32'h068, 32'h12345678, 4'hF, 32'h0,        4, 0, 32'h060, 32'h0,   0,  9, 6, 0);
        tbl[15] = mk(0, 32'h068, 32'h0,        4'h0, 32'h12345678, 0, 0, 32'h0,   32'h0,   2, 10, 6, 0);
        tbl[16] = mk(1, 32'h104, 32'hCAFEF00D, 4'hF, 32'h0,        0, 0, 32'h0,   32'h0,   2, 11, 6, 0);
        tbl[17] = mk(0, 32'h084, 32'h0,        4'h0, 32'h5A5A0084, 0, 0, 32'h0,   32'h0,   2, 12, 6, 0);
        tbl[18] = mk(0, 32'h140, 32'h0,        4'h0, 32'h5A5A0140, 4, 4, 32'h140, 32'h100, 0, 12, 7, 1);

        for (int i = 0; i < 19; i++) begin
            nr0 = rd_q.size();
            nw0 = wr_q.size();
            if (tbl[i].stall) stall_at = nw0 + 2;
            do_req(tbl[i].st, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, lat, ok);
            check($sformatf("v%0d_rsp_seen", i), {31'd0, ok}, 32'd1);
            check($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].lat > 0) check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_read_beats", i), rd_q.size() - nr0, tbl[i].n_rd);
            check($sformatf("v%0d_write_beats", i), wr_q.size() - nw0, tbl[i].n_wr);
            if (rd_q.size() - nr0 == tbl[i].n_rd) begin
                for (int b = 0; b < tbl[i].n_rd; b++) begin
                    check($sformatf("v%0d_rd_addr%0d", i, b), rd_q[nr0 + b], tbl[i].rf_base + 32'(4 * b));
                end
            end
            if (wr_q.size() - nw0 == tbl[i].n_wr) begin
                for (int b = 0; b < tbl[i].n_wr; b++) begin
                    check($sformatf("v%0d_wr_addr%0d", i, b), wr_q[nw0 + b], tbl[i].wb_base + 32'(4 * b));
                    check($sformatf("v%0d_wr_data%0d", i, b), wd_q[nw0 + b], sh(tbl[i].wb_base + 32'(4 * b)));
                end
            end
            check($sformatf("v%0d_hit_cnt", i), hit_cnt, tbl[i].hits);
            check($sformatf("v%0d_miss_cnt", i), miss_cnt, tbl[i].misses);
            if (tbl[i].n_rd > 0) begin
                for (int b = 0; b < 4; b++) shadow.delete(tbl[i].rf_base + 32'(4 * b));
            end
            if (tbl[i].st) begin
                w = sh(tbl[i].addr);
                for (int b = 0; b < 4; b++) begin
                    if (tbl[i].strb[b]) w[8*b +: 8] = tbl[i].wdata[8*b +: 8];
                end
                shadow[tbl[i].addr] = w;
            end
        end

        // Reset while the third refill word is outstanding.
        nr0 = rd_q.size();
        rs0 = rsp_seen;
        @(negedge clk); #1;
        cpu_req_valid = 1'b1;
        cpu_req_store = 1'b0;
        cpu_req_addr  = 32'h040;
        @(posedge clk);
        @(negedge clk); #1;
        cpu_req_valid = 1'b0;
        n = 0;
        while (rd_q.size() < nr0 + 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_third_beat_issued", rd_q.size() - nr0, 32'd3);
        @(negedge clk); #1;
        check("rst_in_refill_wait", {31'd0, mem_req_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_mem_valid_low", {31'd0, mem_req_valid}, 32'd0);
        check("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("rst_no_cpu_rsp", rsp_seen - rs0, 32'd0);

        nr0 = rd_q.size();
        do_req(1'b0, 32'h050, 32'h0, 4'h0, rd, lat, ok);
        check("post_rst_050_rdata", rd, 32'h5A5A0050);
        check("post_rst_050_reads", rd_q.size() - nr0, 32'd4);
        check("post_rst_050_miss", miss_cnt, 32'd1);
        nr0 = rd_q.size();
        do_req(1'b0, 32'h040, 32'h0, 4'h0, rd, lat, ok);
        check("post_rst_040_rdata", rd, 32'h5A5A0040);
        check("post_rst_040_reads", rd_q.size() - nr0, 32'd4);
        if (rd_q.size() > nr0) check("post_rst_040_first_addr", rd_q[nr0], 32'h040);
        check("post_rst_040_miss", miss_cnt, 32'd2);
        check("post_rst_040_hit", hit_cnt, 32'd0);
        do_req(1'b0, 32'h04C, 32'h0, 4'h0, rd, lat, ok);
        check("post_rst_04c_rdata", rd, 32'h5A5A004C);
        check("post_rst_04c_latency", lat, 32'd2);
        check("post_rst_04c_hit", hit_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
